// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: turns one icache refill request into a single AXI4 INCR read burst
module icache_axi_rd_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int LEN_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]      req_len_i,
  output logic                      req_ready_o,
  output logic [31:0]               req_data_o,
  output logic                      req_last_o,
  output logic                      req_err_o,
  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr_o,
  output logic [3:0]                axi_arid_o,
  output logic [7:0]                axi_arlen_o,
  output logic [2:0]                axi_arsize_o,
  output logic [1:0]                axi_arburst_o,
  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rlast_i,
  input  logic [3:0]                axi_rid_i
);
  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
  state_t state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH:0] cnt;
  logic lane, err, beat, beat_err;
  logic [63:0] rd64;
  assign axi_arsize_o = 3'b010;
  assign axi_arburst_o = 2'b01;
  // beat decode, lane select and AR fields gated so nothing leaks outside AR/R
  always_comb begin
    beat = state == R && axi_rvalid_i;
    rd64 = 64'(axi_rdata_i);
    beat_err = axi_rresp_i != 2'b00 || axi_rid_i != AXI_ID || (axi_rlast_i != (cnt == {1'b0, len}));
    req_ready_o = beat;
    req_last_o = beat && axi_rlast_i;
    req_err_o = req_last_o && (err || beat_err);
    req_data_o = !beat ? 32'd0 : (AXI_DATA_WIDTH == 64 && lane) ? rd64[63:32] : rd64[31:0];
    axi_araddr_o = axi_arvalid_o ? addr : '0;
    axi_arlen_o = axi_arvalid_o ? 8'(len) : 8'd0;
    axi_arid_o = axi_arvalid_o ? AXI_ID : 4'd0;
  end
  // request/burst sequencer with registered arvalid/rready
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      lane <= 1'b0;
      err <= 1'b0;
      axi_arvalid_o <= 1'b0;
      axi_rready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          addr <= req_addr_i;
          len <= req_len_i;
          lane <= req_addr_i[2];
          cnt <= '0;
          err <= 1'b0;
          axi_arvalid_o <= 1'b1;
          state <= AR;
        end
        AR: if (axi_arready_i) begin
          axi_arvalid_o <= 1'b0;
          axi_rready_o <= 1'b1;
          state <= R;
        end
        R: if (axi_rvalid_i) begin
          lane <= ~lane;
          cnt <= cnt + 1'b1;
          err <= err | beat_err;
          if (axi_rlast_i) begin
            axi_rready_o <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb_icache_axi_rd_bridge: directed checks of request capture, AR handshake, beat lanes, errors and reset
module tb_icache_axi_rd_bridge;
  logic clock = 1'b0;
  logic reset;
  logic req_valid_i;
  logic [31:0] req_addr_i;
  logic [7:0] req_len_i;
  logic req_ready_o;
  logic [31:0] req_data_o;
  logic req_last_o, req_err_o;
  logic axi_arvalid_o, axi_arready_i;
  logic [31:0] axi_araddr_o;
  logic [3:0] axi_arid_o;
  logic [7:0] axi_arlen_o;
  logic [2:0] axi_arsize_o;
  logic [1:0] axi_arburst_o;
  logic axi_rvalid_i, axi_rready_o;
  logic [63:0] axi_rdata_i;
  logic [1:0] axi_rresp_i;
  logic axi_rlast_i;
  logic [3:0] axi_rid_i;
  int total = 0;
  int fails = 0;
  always #5 clock = ~clock;
  icache_axi_rd_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_ready_o(req_ready_o), .req_data_o(req_data_o), .req_last_o(req_last_o), .req_err_o(req_err_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i), .axi_araddr_o(axi_araddr_o),
    .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o), .axi_arsize_o(axi_arsize_o),
    .axi_arburst_o(axi_arburst_o), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rlast_i(axi_rlast_i), .axi_rid_i(axi_rid_i)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic req(input logic [31:0] a, input logic [7:0] l);
    req_valid_i = 1'b1;
    req_addr_i = a;
    req_len_i = l;
    #1 chk("idle_no_arvalid", axi_arvalid_o, 0);
    tick;
    axi_arready_i = 1'b1;
    #1 chk("arvalid", axi_arvalid_o, 1);
    chk("araddr", axi_araddr_o, a);
    chk("arlen", axi_arlen_o, l);
    chk("arid", axi_arid_o, 0);
    tick;
    axi_arready_i = 1'b0;
  endtask
  task automatic beat(input string tag, input logic [63:0] d, input logic l, input logic [1:0] rs,
                      input logic [31:0] ed, input logic el, input logic ee);
    axi_rvalid_i = 1'b1;
    axi_rdata_i = d;
    axi_rlast_i = l;
    axi_rresp_i = rs;
    #1 chk({tag, "_rready"}, axi_rready_o, 1);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_data"}, req_data_o, ed);
    chk({tag, "_last"}, req_last_o, el);
    chk({tag, "_err"}, req_err_o, ee);
    tick;
    axi_rvalid_i = 1'b0;
    axi_rlast_i = 1'b0;
    axi_rresp_i = 2'b00;
  endtask
  task automatic finish_req;
    #1 chk("done_rready", axi_rready_o, 0);
    chk("done_arvalid", axi_arvalid_o, 0);
    chk("done_ready", req_ready_o, 0);
    req_valid_i = 1'b0;
    tick;
    chk("idle_arvalid", axi_arvalid_o, 0);
    tick;
  endtask
  initial begin
    logic [8:0] gaps;
    int b;
    reset = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_len_i = '0;
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b0;
    axi_rdata_i = '0;
    axi_rresp_i = '0;
    axi_rlast_i = 1'b0;
    axi_rid_i = '0;
    tick;
    tick;
    chk("rst_arvalid", axi_arvalid_o, 0);
    chk("rst_rready", axi_rready_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_araddr", axi_araddr_o, 0);
    chk("arsize", axi_arsize_o, 3'b010);
    chk("arburst", axi_arburst_o, 2'b01);
    reset = 1'b0;
    tick;
    req(32'h3000_0004, 8'd0);
    beat("t1", 64'hAAAA_BBBB_1111_2222, 1'b1, 2'b00, 32'hAAAA_BBBB, 1'b1, 1'b0);
    finish_req;
    req_valid_i = 1'b1;
    req_addr_i = 32'h8000_0000;
    req_len_i = 8'd3;
    tick;
    req_addr_i = 32'h1234_5678;
    req_len_i = 8'd9;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ar_hold_valid", axi_arvalid_o, 1);
      chk("ar_hold_addr", axi_araddr_o, 32'h8000_0000);
      chk("ar_hold_len", axi_arlen_o, 3);
      tick;
    end
    axi_arready_i = 1'b1;
    tick;
    axi_arready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      beat("t2", {32'hB000_0000 | i, 32'hA000_0000 | i}, i == 3, 2'b00,
           (i % 2) ? 32'hB000_0000 | i : 32'hA000_0000 | i, i == 3, 1'b0);
    finish_req;
    req(32'h0000_0000, 8'd3);
    gaps = 9'b100011001;
    b = 0;
    for (int c = 0; c < 9; c++) begin
      if (gaps[c]) begin
        beat("t3", {32'hD000_0000 | b, 32'hC000_0000 | b}, b == 3, 2'b00,
             (b % 2) ? 32'hD000_0000 | b : 32'hC000_0000 | b, b == 3, 1'b0);
        b++;
      end else begin
        axi_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 chk("t3_gap_ready", req_ready_o, 0);
        chk("t3_gap_data", req_data_o, 0);
        tick;
      end
    end
    finish_req;
    req(32'h0000_0100, 8'd3);
    for (int i = 0; i < 4; i++)
      beat("t4", {32'h2222_0000 | i, 32'h1111_0000 | i}, i == 3, (i == 1) ? 2'b10 : 2'b00,
           (i % 2) ? 32'h2222_0000 | i : 32'h1111_0000 | i, i == 3, i == 3);
    finish_req;
    req(32'h0000_0008, 8'd0);
    beat("t4b", 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b0);
    finish_req;
    req(32'h0000_0200, 8'd3);
    beat("t5a", 64'h0000_0002_0000_0001, 1'b0, 2'b00, 32'h0000_0001, 1'b0, 1'b0);
    beat("t5b", 64'h0000_0004_0000_0003, 1'b1, 2'b00, 32'h0000_0004, 1'b1, 1'b1);
    finish_req;
    req(32'h0000_0300, 8'd0);
    beat("t5c", 64'h0000_0006_0000_0005, 1'b0, 2'b00, 32'h0000_0005, 1'b0, 1'b0);
    beat("t5d", 64'h0000_0008_0000_0007, 1'b1, 2'b00, 32'h0000_0008, 1'b1, 1'b1);
    finish_req;
    req(32'h0000_0400, 8'd3);
    beat("t6a", 64'h0000_000A_0000_0009, 1'b0, 2'b00, 32'h0000_0009, 1'b0, 1'b0);
    reset = 1'b1;
    req_valid_i = 1'b0;
    axi_rvalid_i = 1'b1;
    tick;
    chk("t6_rst_arvalid", axi_arvalid_o, 0);
    chk("t6_rst_rready", axi_rready_o, 0);
    chk("t6_rst_ready", req_ready_o, 0);
    chk("t6_rst_data", req_data_o, 0);
    reset = 1'b0;
    axi_rvalid_i = 1'b0;
    tick;
    chk("t6_idle_arvalid", axi_arvalid_o, 0);
    req(32'h0000_0504, 8'd1);
    beat("t6b", 64'h0000_0011_0000_0010, 1'b0, 2'b00, 32'h0000_0011, 1'b0, 1'b0);
    beat("t6c", 64'h0000_0013_0000_0012, 1'b1, 2'b00, 32'h0000_0012, 1'b1, 1'b0);
    finish_req;
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Downstream neighbour of the instruction cache. Converts the cache's simple read-refill request (valid/addr/len) into one AXI4 read burst on the AR/R channels.
- Returns each beat to the cache with ready/data/last.
- Sits between the cache's refill port and the SoC AXI crossbar/arbiter. Read-only, one outstanding transaction.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of request and ARADDR
- AXI_DATA_WIDTH, 64, AXI R data width; legal values 32 or 64
- AXI_ID, 0, constant ARID value (4 bits)
- LEN_WIDTH, 8, width of request burst length (AXI ARLEN encoding: beats-1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid_i  in  1  cache refill request; held high until req_last_o is seen
- req_addr_i  in  AXI_ADDR_WIDTH  byte address of first word (4-byte aligned)
- req_len_i  in  LEN_WIDTH  beats-1
- req_ready_o  out  1  beat valid to cache this cycle
- req_data_o  out  32  beat data (selected 32-bit lane)
- req_last_o  out  1  final beat of burst this cycle
- req_err_o  out  1  asserted with req_last_o if any beat had RRESP!=0 or a length mismatch
- axi_arvalid_o  out  1
- axi_arready_i  in  1
- axi_araddr_o  out  AXI_ADDR_WIDTH
- axi_arid_o  out  4
- axi_arlen_o  out  8
- axi_arsize_o  out  3  constant 3'b010 (4 bytes)
- axi_arburst_o  out  2  constant 2'b01 (INCR)
- axi_rvalid_i  in  1
- axi_rready_o  out  1
- axi_rdata_i  in  AXI_DATA_WIDTH
- axi_rresp_i  in  2
- axi_rlast_i  in  1
- axi_rid_i  in  4  ignored except for an id mismatch, which counts as an error

Behaviour:

Reset:
- Reset takes effect at the next posedge. State goes to IDLE and every output is 0 (arsize/arburst constants excepted).
- Reset mid-burst abandons the transaction; arvalid_o and rready_o are low from the cycle after reset is sampled.

States: IDLE, AR, R, DONE.

IDLE:
- On req_valid_i=1, latch addr, len and addr[2] (lane pointer).
- Clear the beat counter and error flag; go to AR.
- No AXI output is driven in IDLE.

AR:
- axi_arvalid_o=1 with the latched araddr/arlen/arid.
- araddr, arlen and arvalid stay stable until axi_arready_i=1, then go to R.
- arvalid never drops before the handshake.

R:
- axi_rready_o=1.
- Each cycle with rvalid_i=1 is one beat:
  - req_ready_o=1 combinationally.
  - req_data_o = rdata[63:32] if AXI_DATA_WIDTH=64 and the lane pointer is 1, else rdata[31:0].
  - After each beat the lane pointer toggles (INCR by 4 bytes) and the beat counter increments (LEN_WIDTH+1 bits).
- Error flag is set on rresp!=0, on rid!=AXI_ID, or on rlast_i asserted when counter!=len.
- If counter reaches len without rlast_i, the burst continues until rlast_i; the error flag is set.
- On the beat with rlast_i=1:
  - req_last_o=1.
  - req_err_o = error flag OR this beat's error condition.
  - Go to DONE.
- req_ready_o, req_data_o and req_last_o are 0 whenever rvalid_i=0 or state!=R (data forced to 0).

DONE:
- One-cycle guard so a still-high req_valid_i is not re-accepted in the same cycle the cache retires; all outputs 0.
- Go to IDLE next cycle.

Request-side rules:
- Latency from req_valid_i rising to axi_arvalid_o = 1 cycle.
- req_addr_i and req_len_i are sampled only in IDLE; later changes are ignored.
- If req_valid_i drops while in AR or R, the transaction still completes on AXI; the beats are presented but the cache may ignore them.

Simultaneous events:
- arready_i=1 in the first AR cycle: AR lasts exactly one cycle.
- rvalid_i=1 in the cycle after the AR handshake is accepted normally.

Test Plan:
- len=0, addr=0x3000_0004, arready same cycle, rdata=64'hAAAA_BBBB_1111_2222 with rlast → araddr=0x30000004, arlen=0, arsize=2, arburst=1; beat 2 cycles after req_valid; req_data=0xAAAABBBB, req_ready=req_last=1, req_err=0; DONE then IDLE.
- len=3, addr=0x8000_0000, AXI_DATA_WIDTH=64, arready delayed 4 cycles → arvalid/araddr stable 4 cycles; 4 beats return lanes low,high,low,high; req_last only on beat 4.
- rvalid gaps (beats at cycles 0,3,4,8) → req_ready mirrors rvalid exactly, no lost/duplicate beats, counter ends at 3.
- rresp=2'b10 on beat 2 of 4 → req_err_o=1 with req_last_o; next request has req_err_o=0.
- rlast on beat 2 with len=3 → burst ends, req_last=1, req_err=1; bridge returns to IDLE.
- reset asserted during R after beat 1 → next cycle arvalid=rready=req_ready=0, state IDLE; fresh request afterwards completes normally.
